din_buffer: RTL and testbench
=============================

# din_buffer

Data input buffer for the simplecore datapath, the input-side counterpart of the data output register. Captures 16-bit words arriving from external memory/IO over a valid/ready handshake into a small FIFO and delivers them one at a time onto internal bus A when the control unit asserts the data-in control. It decouples external read latency from core sequencing.

## Interface

Parameters:
- WIDTH, 16, data word width.
- DEPTH, 4, FIFO entries; power of 2, at least 2.

Ports:
- clk  input  1  single clock for the block, rising-edge.
- rst_n  input  1  reset, asynchronous assert, active-low.
- dIn  input  WIDTH  incoming data word from external memory/IO.
- dInValid  input  1  dIn holds a valid word this cycle.
- dInReady  output  1  buffer accepts a word this cycle; equals !full, combinational from state.
- dInCtl  input  1  control unit pops the head word onto busA.
- busA  output  WIDTH  registered bus A data; holds the last popped word.
- dInFlush  input  1  synchronous flush of buffered words.
- dInEmpty  output  1  count == 0.
- dInCount  output  clog2(DEPTH)+1  number of buffered words, 0..DEPTH.
- dInUnf  output  1  sticky underflow flag: pop requested while empty.

## Operation

- Storage: DEPTH x WIDTH array; write pointer wp and read pointer rp, each clog2(DEPTH) bits, wrap modulo DEPTH; separate count register.
- Push: dInValid && dInReady at a rising edge writes dIn to mem[wp] and increments wp.
- Pop: dInCtl && !dInEmpty at a rising edge loads busA <= mem[rp] and increments rp.
- Count: +1 on push only, -1 on pop only, unchanged on both or neither.
- Full (count == DEPTH): dInReady = 0, so no push even if a pop occurs in the same cycle. There is no pass-through.
- Empty with dInCtl = 1: no pop; busA holds; dInUnf set to 1.
  - This holds even if a push occurs in the same cycle. The pushed word is stored and count becomes 1.
- dInUnf stays 1 until dInFlush or reset.
- dInFlush (highest priority) clears wp, rp, count and dInUnf at the edge.
  - Any push or pop in the same cycle is dropped.
  - busA holds its value.
- Reset (rst_n low, asynchronous):
  - wp = rp = 0, count = 0, busA = 0, dInUnf = 0.
  - Outputs during reset: dInEmpty = 1, dInReady = 1, dInCount = 0.
  - No push or pop takes effect while rst_n is low.
  - Reset mid-transfer discards all buffered words.
- Buffer contents are not reset; stale contents are never visible on busA.

## Timing

- Push latency: a word accepted at edge N is poppable at edge N+1; count reflects it after edge N.
- Pop latency: dInCtl sampled at edge N, word on busA after edge N, stable through the following cycle.
- dInReady, dInEmpty and dInCount are functions of registered count only. There is no combinational path from dIn, dInValid or dInCtl.
- Ordering: strict FIFO; words leave in acceptance order across pointer wrap.
- Throughput: one push and one pop per cycle sustained when 0 < count < DEPTH.
- Source must hold dIn and dInValid until dInReady is seen high at an edge.

## Test plan

- Reset: assert rst_n low mid-cycle with count = 3 -> immediately dInCount = 0, dInEmpty = 1, busA = 0x0000, dInUnf = 0, dInReady = 1.
- Fill: push 0x1111, 0x2222, 0x3333, 0x4444 on consecutive cycles, then hold dInValid with 0x5555.
  - Required: dInCount = 4, dInReady = 0, and 0x5555 is not stored.
  - Then pop 4 times: busA = 0x1111, 0x2222, 0x3333, 0x4444 on successive cycles, dInEmpty = 1.
- Simultaneous push/pop at count 2: push 0xAAAA with dInCtl = 1 -> count stays 2, busA = old head, 0xAAAA emerges after the 2 older words.
- Underflow: empty buffer, dInCtl = 1 with push 0xBEEF.
  - Required: dInUnf = 1, busA unchanged, count = 1.
  - Next pop gives busA = 0xBEEF; dInUnf stays 1 until dInFlush.
- Flush priority: count = 3, assert dInFlush with dInValid and dInCtl high -> count = 0, dInUnf = 0, busA unchanged, no word stored.
- Wrap-around: stream 0x0001..0x000A with interleaved pops keeping count between 1 and 3 -> busA sequence is 0x0001..0x000A in order, no loss or duplication.

Source files
------------

// File: rtl/din_buffer.sv
`default_nettype none
// ============================================================================
// Module   : din_buffer
// Purpose  : Data input buffer for the simplecore datapath. Captures words
//            from external memory/IO over a valid/ready handshake into a
//            small FIFO and delivers them one at a time onto internal bus A
//            when the control unit asserts dInCtl.
// Ports    : clk       - rising-edge clock
//            rst_n     - asynchronous active-low reset
//            dIn       - incoming data word
//            dInValid  - dIn holds a valid word
//            dInReady  - buffer can accept a word (not full)
//            dInCtl    - pop head word onto busA
//            busA      - registered bus A data, holds last popped word
//            dInFlush  - synchronous flush of buffered words
//            dInEmpty  - no words buffered
//            dInCount  - number of buffered words, 0..DEPTH
//            dInUnf    - sticky underflow flag (pop requested while empty)
// Revision : 1.0 - initial release
// ============================================================================
module din_buffer #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [WIDTH-1:0]           dIn,
  input  logic                       dInValid,
  output logic                       dInReady,
  input  logic                       dInCtl,
  output logic [WIDTH-1:0]           busA,
  input  logic                       dInFlush,
  output logic                       dInEmpty,
  output logic [$clog2(DEPTH):0]     dInCount,
  output logic                       dInUnf
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  // Storage array: deliberately not reset. The pointers and count guarantee
  // an entry is only read after it has been written since the last
  // reset/flush, so stale contents never reach busA.
  logic [WIDTH-1:0] mem_q [DEPTH];

  logic [PW-1:0]    wp_q, wp_d;
  logic [PW-1:0]    rp_q, rp_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] bus_q, bus_d;
  logic             unf_q, unf_d;

  logic             full;
  logic             empty;
  logic             push;
  logic             pop;
  logic             mem_we;

  // Status flags depend only on the registered count.
  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);

  // No pass-through: a full buffer refuses a push even if a pop frees a slot
  // in the same cycle.
  assign push = dInValid && !full;
  assign pop  = dInCtl && !empty;

  // Flush drops any same-cycle push; reset suppresses writes as well.
  assign mem_we = push && !dInFlush && rst_n;

  always_comb begin
    wp_d    = wp_q;
    rp_d    = rp_q;
    count_d = count_q;
    bus_d   = bus_q;
    unf_d   = unf_q;

    if (dInFlush) begin
      // busA intentionally holds its value across a flush.
      wp_d    = '0;
      rp_d    = '0;
      count_d = '0;
      unf_d   = 1'b0;
    end else begin
      if (push) begin
        wp_d = wp_q + PW'(1);
      end
      if (pop) begin
        bus_d = mem_q[rp_q];
        rp_d  = rp_q + PW'(1);
      end
      if (push && !pop) begin
        count_d = count_q + CW'(1);
      end else if (pop && !push) begin
        count_d = count_q - CW'(1);
      end
      // Underflow is flagged even when a push lands in the same cycle.
      if (dInCtl && empty) begin
        unf_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp_q    <= '0;
      rp_q    <= '0;
      count_q <= '0;
      bus_q   <= '0;
      unf_q   <= 1'b0;
    end else begin
      wp_q    <= wp_d;
      rp_q    <= rp_d;
      count_q <= count_d;
      bus_q   <= bus_d;
      unf_q   <= unf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[wp_q] <= dIn;
    end
  end

  assign dInReady = !full;
  assign dInEmpty = empty;
  assign dInCount = count_q;
  assign busA     = bus_q;
  assign dInUnf   = unf_q;

endmodule
`default_nettype wire

// File: tb/tb_din_buffer.sv
`default_nettype none
// ============================================================================
// Module   : tb_din_buffer
// Purpose  : Directed self-checking bench for din_buffer (WIDTH=16, DEPTH=4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_din_buffer;

  logic        clk;
  logic        rst_n;
  logic [15:0] dIn;
  logic        dInValid;
  logic        dInReady;
  logic        dInCtl;
  logic [15:0] busA;
  logic        dInFlush;
  logic        dInEmpty;
  logic [2:0]  dInCount;
  logic        dInUnf;

  int checks   = 0;
  int failures = 0;

  din_buffer #(.WIDTH(16), .DEPTH(4)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .dIn      (dIn),
    .dInValid (dInValid),
    .dInReady (dInReady),
    .dInCtl   (dInCtl),
    .busA     (busA),
    .dInFlush (dInFlush),
    .dInEmpty (dInEmpty),
    .dInCount (dInCount),
    .dInUnf   (dInUnf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of inputs, then sample 1 time unit after the edge.
  task automatic step(input logic v, input logic [15:0] d, input logic c, input logic f);
    dInValid = v;
    dIn      = d;
    dInCtl   = c;
    dInFlush = f;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n    = 1'b0;
    dIn      = 16'h0000;
    dInValid = 1'b0;
    dInCtl   = 1'b0;
    dInFlush = 1'b0;

    // Reset state
    #12;
    check("rst_count", 32'(dInCount), 32'd0);
    check("rst_empty", 32'(dInEmpty), 32'd1);
    check("rst_ready", 32'(dInReady), 32'd1);
    check("rst_busA",  32'(busA),     32'h0000);
    check("rst_unf",   32'(dInUnf),   32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Fill to full
    step(1'b1, 16'h1111, 1'b0, 1'b0);
    check("fill1_count", 32'(dInCount), 32'd1);
    step(1'b1, 16'h2222, 1'b0, 1'b0);
    step(1'b1, 16'h3333, 1'b0, 1'b0);
    step(1'b1, 16'h4444, 1'b0, 1'b0);
    check("full_count", 32'(dInCount), 32'd4);
    check("full_ready", 32'(dInReady), 32'd0);
    check("full_empty", 32'(dInEmpty), 32'd0);
    step(1'b1, 16'h5555, 1'b0, 1'b0);
    check("full_hold_count", 32'(dInCount), 32'd4);
    check("full_hold_ready", 32'(dInReady), 32'd0);

    // Drain
    step(1'b0, 16'h0000, 1'b1, 1'b0);
    check("pop1_busA",  32'(busA),     32'h1111);
    check("pop1_count", 32'(dInCount), 32'd3);
    check("pop1_ready", 32'(dInReady), 32'd1);
    step(1'b0, 16'h0000, 1'b1, 1'b0);
    check("pop2_busA", 32'(busA), 32'h2222);
    step(1'b0, 16'h0000, 1'b1, 1'b0);
    check("pop3_busA", 32'(busA), 32'h3333);
    step(1'b0, 16'h0000, 1'b1, 1'b0);
    check("pop4_busA",  32'(busA),     32'h4444);
    check("pop4_empty", 32'(dInEmpty), 32'd1);
    check("pop4_count", 32'(dInCount), 32'd0);
    check("pop4_unf",   32'(dInUnf),   32'd0);

    // Simultaneous push/pop at count 2
    step(1'b1, 16'h0B01, 1'b0, 1'b0);
    step(1'b1, 16'h0B02, 1'b0, 1'b0);
    check("sim_pre_count", 32'(dInCount), 32'd2);
    step(1'b1, 16'hAAAA, 1'b1, 1'b0);
    check("sim_busA",  32'(busA),     32'h0B01);
    check("sim_count", 32'(dInCount), 32'd2);
    step(1'b0, 16'h0000, 1'b1, 1'b0);
    check("sim_pop1_busA", 32'(busA), 32'h0B02);
    step(1'b0, 16'h0000, 1'b1, 1'b0);
    check("sim_pop2_busA",  32'(busA),     32'hAAAA);
    check("sim_pop2_empty", 32'(dInEmpty), 32'd1);

    // Underflow with simultaneous push
    step(1'b1, 16'hBEEF, 1'b1, 1'b0);
    check("unf_flag",  32'(dInUnf),   32'd1);
    check("unf_busA",  32'(busA),     32'hAAAA);
    check("unf_count", 32'(dInCount), 32'd1);
    step(1'b0, 16'h0000, 1'b1, 1'b0);
    check("unf_pop_busA", 32'(busA),   32'hBEEF);
    check("unf_sticky",   32'(dInUnf), 32'd1);

    // Flush priority
    step(1'b1, 16'hC001, 1'b0, 1'b0);
    step(1'b1, 16'hC002, 1'b0, 1'b0);
    step(1'b1, 16'hC003, 1'b0, 1'b0);
    check("flush_pre_count", 32'(dInCount), 32'd3);
    check("flush_pre_unf",   32'(dInUnf),   32'd1);
    step(1'b1, 16'hDEAD, 1'b1, 1'b1);
    check("flush_count", 32'(dInCount), 32'd0);
    check("flush_unf",   32'(dInUnf),   32'd0);
    check("flush_busA",  32'(busA),     32'hBEEF);
    check("flush_empty", 32'(dInEmpty), 32'd1);

    // Wrap-around stream 0x0001..0x000A
    step(1'b1, 16'h0001, 1'b0, 1'b0);
    step(1'b1, 16'h0002, 1'b0, 1'b0);
    for (int k = 3; k <= 10; k++) begin
      step(1'b1, 16'(k), 1'b1, 1'b0);
      check($sformatf("wrap_busA_%0d", k - 2), 32'(busA), 32'(k - 2));
      check($sformatf("wrap_count_%0d", k), 32'(dInCount), 32'd2);
    end
    step(1'b0, 16'h0000, 1'b1, 1'b0);
    check("wrap_busA_9", 32'(busA), 32'h0009);
    step(1'b0, 16'h0000, 1'b1, 1'b0);
    check("wrap_busA_10", 32'(busA),     32'h000A);
    check("wrap_empty",   32'(dInEmpty), 32'd1);
    check("wrap_unf",     32'(dInUnf),   32'd0);

    // Underflow on empty buffer without push
    step(1'b0, 16'h0000, 1'b1, 1'b0);
    check("unf2_flag", 32'(dInUnf), 32'd1);
    check("unf2_busA", 32'(busA),   32'h000A);

    // Reset mid-transfer with count = 3
    step(1'b1, 16'h0D01, 1'b0, 1'b0);
    step(1'b1, 16'h0D02, 1'b0, 1'b0);
    step(1'b1, 16'h0D03, 1'b0, 1'b0);
    check("mrst_pre_count", 32'(dInCount), 32'd3);
    dInValid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check("mrst_count", 32'(dInCount), 32'd0);
    check("mrst_empty", 32'(dInEmpty), 32'd1);
    check("mrst_busA",  32'(busA),     32'h0000);
    check("mrst_unf",   32'(dInUnf),   32'd0);
    check("mrst_ready", 32'(dInReady), 32'd1);
    // Activity while held in reset has no effect.
    step(1'b1, 16'h0E01, 1'b1, 1'b0);
    check("mrst_hold_count", 32'(dInCount), 32'd0);
    check("mrst_hold_unf",   32'(dInUnf),   32'd0);
    check("mrst_hold_busA",  32'(busA),     32'h0000);
    dInValid = 1'b0;
    dInCtl   = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b0, 16'h0000, 1'b0, 1'b0);
    check("post_rst_count", 32'(dInCount), 32'd0);
    check("post_rst_empty", 32'(dInEmpty), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
